l3_axi_mem: RTL and testbench

L3_AXI_MEM -- requirements
Module: l3_axi_mem

---
 rtl/l3_axi_pkg.sv | 24 ++
 rtl/axi_lat_ctr.sv | 28 ++
 rtl/l3_axi_mem.sv | 223 ++++++++++++++++++++++
 tb/tb_l3_axi_mem.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l3_axi_pkg.sv
// Shared types and defaults for the L3 AXI4-lite backing store.
package l3_axi_pkg;

   localparam int DEF_RD_LATENCY = 4;
   localparam int DEF_WR_LATENCY = 2;
   localparam int LAT_CTR_W      = 16;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_WAIT = 2'd1,
      RD_RESP = 2'd2
   } rd_state_t;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_WAIT = 2'd1,
      WR_RESP = 2'd2
   } wr_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/axi_lat_ctr.sv
// Loadable down-counter; done is high while the count sits at zero.
module axi_lat_ctr #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             done
);

   logic [WIDTH-1:0] count_r;

   // Load has priority; decrement stops at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_r <= {WIDTH{1'b0}};
      end else if (load) begin
         count_r <= load_val;
      end else if (en && (count_r != {WIDTH{1'b0}})) begin
         count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   assign done = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/l3_axi_mem.sv
// AXI4-lite single-beat slave backing store: independent read and write FSMs
// with fixed latencies, byte strobes and write-to-read forwarding on collision.
module l3_axi_mem
   import l3_axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WORDS  = 4096,
   parameter int RD_LATENCY = DEF_RD_LATENCY,
   parameter int WR_LATENCY = DEF_WR_LATENCY
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ADDR_WIDTH-1:0]   s_araddr,
   input  logic                    s_arvalid,
   output logic                    s_arready,
   output logic [DATA_WIDTH-1:0]   s_rdata,
   output logic                    s_rvalid,
   input  logic                    s_rready,
   input  logic [ADDR_WIDTH-1:0]   s_awaddr,
   input  logic                    s_awvalid,
   output logic                    s_awready,
   input  logic [DATA_WIDTH-1:0]   s_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_wstrb,
   input  logic                    s_wvalid,
   output logic                    s_wready,
   output logic                    s_bvalid,
   input  logic                    s_bready,
   output logic [15:0]             rd_count,
   output logic [15:0]             wr_count
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int NB    = DATA_WIDTH / 8;
   localparam logic [LAT_CTR_W-1:0] RD_LOAD = LAT_CTR_W'(RD_LATENCY - 1);
   localparam logic [LAT_CTR_W-1:0] WR_LOAD = LAT_CTR_W'(WR_LATENCY - 1);

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   rd_state_t             rd_state_r;
   wr_state_t             wr_state_r;
   logic [IDX_W-1:0]      ridx_r, widx_r;
   logic [DATA_WIDTH-1:0] wdata_r, rdata_r;
   logic [NB-1:0]         wstrb_r;
   logic                  aw_cap_r, w_cap_r;
   logic                  arready_r, awready_r, wready_r, rvalid_r, bvalid_r;
   logic [15:0]           rd_count_r, wr_count_r;

   logic                  ar_hs_s, aw_hs_s, w_hs_s, aw_have_s, w_have_s;
   logic                  wr_load_s, wr_commit_s, rd_done_s, wr_done_s;
   logic [DATA_WIDTH-1:0] merged_s, rd_word_s;
   logic                  unused_addr_bits;

   assign ar_hs_s     = s_arvalid && arready_r;
   assign aw_hs_s     = s_awvalid && awready_r;
   assign w_hs_s      = s_wvalid && wready_r;
   assign aw_have_s   = aw_cap_r || aw_hs_s;
   assign w_have_s    = w_cap_r || w_hs_s;
   assign wr_load_s   = (wr_state_r == WR_IDLE) && aw_have_s && w_have_s;
   assign wr_commit_s = (wr_state_r == WR_WAIT) && wr_done_s;
   assign unused_addr_bits = ^{s_araddr[ADDR_WIDTH-1:IDX_W], s_awaddr[ADDR_WIDTH-1:IDX_W]};

   axi_lat_ctr #(.WIDTH(LAT_CTR_W)) u_rd_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ar_hs_s),
      .load_val (RD_LOAD),
      .en       (rd_state_r == RD_WAIT),
      .done     (rd_done_s)
   );

   axi_lat_ctr #(.WIDTH(LAT_CTR_W)) u_wr_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (wr_load_s),
      .load_val (WR_LOAD),
      .en       (wr_state_r == WR_WAIT),
      .done     (wr_done_s)
   );

   // Strobe merge of the pending write over the current word.
   always_comb begin
      merged_s = mem[widx_r];
      for (int b = 0; b < NB; b++) begin
         merged_s[b*8 +: 8] = wstrb_r[b] ? wdata_r[b*8 +: 8] : mem[widx_r][b*8 +: 8];
      end
   end

   // A commit landing on the sampled index forwards the merged word.
   always_comb begin
      if (wr_commit_s && (widx_r == ridx_r)) begin
         rd_word_s = merged_s;
      end else begin
         rd_word_s = mem[ridx_r];
      end
   end

   // Storage is never reset; a commit in a reset cycle is suppressed.
   always_ff @(posedge clk) begin
      if (rst_n && wr_commit_s) begin
         mem[widx_r] <= merged_s;
      end
   end

   // Address/data capture registers.
   always_ff @(posedge clk) begin
      if (ar_hs_s) begin
         ridx_r <= s_araddr[IDX_W-1:0];
      end
      if (aw_hs_s) begin
         widx_r <= s_awaddr[IDX_W-1:0];
      end
      if (w_hs_s) begin
         wdata_r <= s_wdata;
         wstrb_r <= s_wstrb;
      end
   end

   // Read FSM; rdata is zero whenever rvalid is low.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_state_r <= RD_IDLE;
         arready_r  <= 1'b1;
         rvalid_r   <= 1'b0;
         rdata_r    <= {DATA_WIDTH{1'b0}};
         rd_count_r <= 16'd0;
      end else begin
         case (rd_state_r)
            RD_IDLE: begin
               if (ar_hs_s) begin
                  rd_state_r <= RD_WAIT;
                  arready_r  <= 1'b0;
               end
            end
            RD_WAIT: begin
               if (rd_done_s) begin
                  rdata_r    <= rd_word_s;
                  rvalid_r   <= 1'b1;
                  rd_state_r <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (s_rready) begin
                  rvalid_r   <= 1'b0;
                  rdata_r    <= {DATA_WIDTH{1'b0}};
                  arready_r  <= 1'b1;
                  rd_state_r <= RD_IDLE;
                  rd_count_r <= sat_inc16(rd_count_r);
               end
            end
            default: begin
               rd_state_r <= RD_IDLE;
               arready_r  <= 1'b1;
               rvalid_r   <= 1'b0;
               rdata_r    <= {DATA_WIDTH{1'b0}};
            end
         endcase
      end
   end

   // Write FSM; AW and W are captured independently before the latency count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_state_r <= WR_IDLE;
         aw_cap_r   <= 1'b0;
         w_cap_r    <= 1'b0;
         awready_r  <= 1'b1;
         wready_r   <= 1'b1;
         bvalid_r   <= 1'b0;
         wr_count_r <= 16'd0;
      end else begin
         case (wr_state_r)
            WR_IDLE: begin
               aw_cap_r <= aw_have_s;
               w_cap_r  <= w_have_s;
               if (aw_have_s && w_have_s) begin
                  awready_r  <= 1'b0;
                  wready_r   <= 1'b0;
                  wr_state_r <= WR_WAIT;
               end else begin
                  awready_r <= !aw_have_s;
                  wready_r  <= !w_have_s;
               end
            end
            WR_WAIT: begin
               if (wr_done_s) begin
                  bvalid_r   <= 1'b1;
                  wr_state_r <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (s_bready) begin
                  bvalid_r   <= 1'b0;
                  aw_cap_r   <= 1'b0;
                  w_cap_r    <= 1'b0;
                  awready_r  <= 1'b1;
                  wready_r   <= 1'b1;
                  wr_state_r <= WR_IDLE;
                  wr_count_r <= sat_inc16(wr_count_r);
               end
            end
            default: begin
               wr_state_r <= WR_IDLE;
               aw_cap_r   <= 1'b0;
               w_cap_r    <= 1'b0;
               awready_r  <= 1'b1;
               wready_r   <= 1'b1;
               bvalid_r   <= 1'b0;
            end
         endcase
      end
   end

   assign s_arready = arready_r;
   assign s_rvalid  = rvalid_r;
   assign s_rdata   = rdata_r;
   assign s_awready = awready_r;
   assign s_wready  = wready_r;
   assign s_bvalid  = bvalid_r;
   assign rd_count  = rd_count_r;
   assign wr_count  = wr_count_r;

endmodule

// File: tb/tb_l3_axi_mem.sv
// Directed and scoreboard-based bench for l3_axi_mem (default parameters).
module tb_l3_axi_mem;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] s_araddr, s_awaddr, s_wdata, s_rdata;
   logic        s_arvalid, s_arready, s_rvalid, s_rready;
   logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic [3:0]  s_wstrb;
   logic [15:0] rd_count, wr_count;

   int checks = 0;
   int passed = 0;
   logic [31:0] model [int];
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   l3_axi_mem dut (
      .clk(clk), .rst_n(rst_n),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bvalid(s_bvalid), .s_bready(s_bready),
      .rd_count(rd_count), .wr_count(wr_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] strb);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[b*8 +: 8] = strb[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_rd(input logic [31:0] addr);
      int idx;
      idx = int'(addr[11:0]);
      return model.exists(idx) ? model[idx] : 32'h0;
   endfunction

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output int lat);
      int n;
      n = 0;
      s_awaddr = addr; s_wdata = data; s_wstrb = strb;
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      while (!(s_awready && s_wready) && n < 50) begin tick(); n++; end
      tick();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      model[int'(addr[11:0])] = merge(model_rd(addr), data, strb);
      lat = 0;
      while (!s_bvalid && lat < 50) begin tick(); lat++; end
      s_bready = 1'b1;
      tick();
      s_bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, output int lat, output logic [31:0] data);
      int n;
      n = 0;
      s_araddr = addr; s_arvalid = 1'b1;
      while (!s_arready && n < 50) begin tick(); n++; end
      tick();
      s_arvalid = 1'b0;
      exp_q.push_back(model_rd(addr));
      lat = 0;
      while (!s_rvalid && lat < 50) begin tick(); lat++; end
      data = s_rdata;
      s_rready = 1'b1;
      tick();
      s_rready = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (s_arready !== 1'b1) $display("FAIL reset_arready: got %b want 1", s_arready); else passed++;
      checks++; if (s_awready !== 1'b1 || s_wready !== 1'b1)
         $display("FAIL reset_awready_wready: got %b%b want 11", s_awready, s_wready); else passed++;
      checks++; if (s_rvalid !== 1'b0 || s_bvalid !== 1'b0)
         $display("FAIL reset_valids: got rvalid=%b bvalid=%b want 0 0", s_rvalid, s_bvalid); else passed++;
      checks++; if (s_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", s_rdata); else passed++;
      checks++; if (rd_count !== 16'd0 || wr_count !== 16'd0)
         $display("FAIL reset_counts: got %0d/%0d want 0/0", rd_count, wr_count); else passed++;
   endtask

   task automatic test_write_read();
      int lat;
      logic [31:0] d, e;
      do_write(32'h10, 32'hDEADBEEF, 4'hF, lat);
      checks++; if (lat !== 2) $display("FAIL wr_latency: got %0d want 2", lat); else passed++;
      checks++; if (wr_count !== 16'd1) $display("FAIL wr_count: got %0d want 1", wr_count); else passed++;
      do_read(32'h10, lat, d);
      e = exp_q.pop_front();
      checks++; if (lat !== 4) $display("FAIL rd_latency: got %0d want 4", lat); else passed++;
      checks++; if (d !== e) $display("FAIL rd_data: got %h want %h", d, e); else passed++;
      checks++; if (s_rdata !== 32'h0) $display("FAIL rdata_idle_zero: got %h want 0", s_rdata); else passed++;
      checks++; if (rd_count !== 16'd1) $display("FAIL rd_count: got %0d want 1", rd_count); else passed++;
   endtask

   task automatic test_partial_strobe();
      int lat;
      logic [31:0] d, e;
      do_write(32'h20, 32'hAABBCCDD, 4'hF, lat);
      do_write(32'h20, 32'h11223344, 4'h5, lat);
      do_read(32'h20, lat, d);
      e = exp_q.pop_front();
      checks++; if (d !== e || d !== 32'hAA22CC44)
         $display("FAIL partial_strobe: got %h want %h", d, 32'hAA22CC44); else passed++;
   endtask

   task automatic test_decoupled_write();
      int lat;
      logic [31:0] d, e;
      s_awaddr = 32'h30; s_awvalid = 1'b1;
      tick();
      s_awvalid = 1'b0;
      checks++; if (s_awready !== 1'b0 || s_wready !== 1'b1)
         $display("FAIL decoupled_ready_after_aw: got aw=%b w=%b want 0 1", s_awready, s_wready); else passed++;
      tick(); tick();
      s_wdata = 32'h0BADF00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
      checks++; if (s_wready !== 1'b1) $display("FAIL decoupled_wready_c3: got %b want 1", s_wready); else passed++;
      tick();
      s_wvalid = 1'b0;
      model[int'(12'h030)] = 32'h0BADF00D;
      lat = 0;
      while (!s_bvalid && lat < 50) begin tick(); lat++; end
      checks++; if (lat !== 2) $display("FAIL decoupled_bvalid_cycle: got %0d want 2 after W", lat); else passed++;
      s_bready = 1'b1; tick(); s_bready = 1'b0;
      do_read(32'h30, lat, d);
      e = exp_q.pop_front();
      checks++; if (d !== e) $display("FAIL decoupled_mem: got %h want %h", d, e); else passed++;
   endtask

   task automatic test_backpressure();
      int lat;
      logic [31:0] first, e;
      apply_reset();
      s_araddr = 32'h10; s_arvalid = 1'b1;
      tick();
      exp_q.push_back(model_rd(32'h10));
      lat = 0;
      while (!s_rvalid && lat < 50) begin tick(); lat++; end
      checks++; if (lat !== 4) $display("FAIL bp_latency: got %0d want 4", lat); else passed++;
      first = s_rdata;
      e = exp_q.pop_front();
      checks++; if (first !== e) $display("FAIL bp_data: got %h want %h", first, e); else passed++;
      for (int i = 0; i < 6; i++) begin
         checks++; if (s_rvalid !== 1'b1 || s_rdata !== first || s_arready !== 1'b0)
            $display("FAIL bp_hold_%0d: got v=%b d=%h ar=%b want 1 %h 0", i, s_rvalid, s_rdata, s_arready, first);
         else passed++;
         tick();
      end
      s_rready = 1'b1;
      tick();
      s_rready = 1'b0; s_arvalid = 1'b0;
      repeat (8) tick();
      checks++; if (s_rvalid !== 1'b0 || rd_count !== 16'd1)
         $display("FAIL bp_single_read: got rvalid=%b rd_count=%0d want 0 1", s_rvalid, rd_count); else passed++;
   endtask

   task automatic test_wrap_collision();
      int lat;
      logic [31:0] d, e;
      do_read(32'h1010, lat, d);
      e = exp_q.pop_front();
      checks++; if (d !== e) $display("FAIL wrap_read: got %h want %h", d, e); else passed++;
      do_write(32'h40, 32'h12345678, 4'hF, lat);
      s_araddr = 32'h40; s_arvalid = 1'b1;
      tick();
      s_arvalid = 1'b0;
      tick();
      s_awaddr = 32'h40; s_wdata = 32'hCAFEF00D; s_wstrb = 4'h3;
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      tick();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      model[int'(12'h040)] = merge(model_rd(32'h40), 32'hCAFEF00D, 4'h3);
      exp_q.push_back(model_rd(32'h40));
      tick(); tick();
      checks++; if (s_rvalid !== 1'b1 || s_bvalid !== 1'b1)
         $display("FAIL collision_timing: got rvalid=%b bvalid=%b want 1 1", s_rvalid, s_bvalid); else passed++;
      e = exp_q.pop_front();
      checks++; if (s_rdata !== e) $display("FAIL collision_data: got %h want %h", s_rdata, e); else passed++;
      s_rready = 1'b1; s_bready = 1'b1;
      tick();
      s_rready = 1'b0; s_bready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [31:0] d, e;
      do_write(32'h50, 32'h55AA55AA, 4'hF, lat);
      s_araddr = 32'h50; s_arvalid = 1'b1;
      s_awaddr = 32'h50; s_wdata = 32'hFFFFFFFF; s_wstrb = 4'hF;
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      tick();
      s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++; if (s_rvalid !== 1'b0 || s_bvalid !== 1'b0)
            $display("FAIL rst_mid_no_resp_%0d: got rvalid=%b bvalid=%b want 0 0", i, s_rvalid, s_bvalid);
         else passed++;
         tick();
      end
      checks++; if (rd_count !== 16'd0 || wr_count !== 16'd0)
         $display("FAIL rst_mid_counts: got %0d/%0d want 0/0", rd_count, wr_count); else passed++;
      do_read(32'h50, lat, d);
      e = exp_q.pop_front();
      checks++; if (d !== e) $display("FAIL rst_mid_mem: got %h want %h", d, e); else passed++;
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [31:0] d, e, a;
      for (int i = 0; i < 6; i++) begin
         a = 32'h100 + 32'(i * 7);
         do_write(a, $urandom, 4'hF, lat);
         do_write(a + 32'(i * 4096), $urandom, 4'($urandom_range(1, 15)), lat);
         checks++; if (lat !== 2) $display("FAIL b2b_wr_lat_%0d: got %0d want 2", i, lat); else passed++;
      end
      for (int i = 0; i < 6; i++) begin
         a = 32'h100 + 32'(i * 7) + 32'h2000;
         do_read(a, lat, d);
         e = exp_q.pop_front();
         checks++; if (d !== e || lat !== 4)
            $display("FAIL b2b_rd_%0d: got %h lat %0d want %h lat 4", i, d, lat, e); else passed++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      s_araddr = 32'h0; s_arvalid = 1'b0; s_rready = 1'b0;
      s_awaddr = 32'h0; s_awvalid = 1'b0; s_wdata = 32'h0; s_wstrb = 4'h0;
      s_wvalid = 1'b0; s_bready = 1'b0;
      test_reset();
      test_write_read();
      test_partial_strobe();
      test_decoupled_write();
      test_backpressure();
      test_wrap_collision();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
      $fatal(1);
   end

endmodule
